// File: rtl/ifetch_queue.sv
// Fetch controller for the dynamic pipeline: owns the fetch PC, reads the
// combinational instruction memory, buffers {pc, instr} pairs in a small
// in-order queue and hands them to decode/issue over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the new target.
module ifetch_queue #(
    parameter int          ADDR_W   = 11,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [31:0]                fetch_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage: one PC and one instruction word per entry.
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_fetch_pc;

    logic             w_push;
    logic             w_pop;
    logic             w_valid;

    // Redirect has priority: it suppresses both push and pop so no stale
    // entry can be consumed or written during the flush cycle.
    assign w_valid = (r_count != '0);
    assign w_push  = fetch_en & (r_count < FULL_CNT) & ~redirect_valid;
    assign w_pop   = w_valid & out_ready & ~redirect_valid;

    assign imem_addr = r_fetch_pc[ADDR_W+1:2];
    assign fetch_pc  = r_fetch_pc;
    assign q_count   = r_count;
    assign out_valid = w_valid;

    // Head presentation: zeroed while empty so nothing stale leaks out.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (w_valid) begin
            out_instr = r_q_instr[r_rd_ptr];
            out_pc    = r_q_pc[r_rd_ptr];
        end
    end

    // Control state: fetch PC, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue entry write on push.
    // NOTE: storage is deliberately not reset; occupancy gates every read,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: imem word k holds 32'h1000_0000 + k.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ifetch_queue;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       fetch_pc;
    logic [2:0]        q_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = 32'h1000_0000 + {21'd0, imem_addr};

    ifetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_pc       (fetch_pc),
        .q_count        (q_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc"},    out_pc, pc);
        check({tag, ".instr"}, out_instr, 32'h1000_0000 + {19'd0, pc[ADDR_W+1:2]});
        check({tag, ".count"}, {29'd0, q_count}, {29'd0, cnt});
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.count", {29'd0, q_count}, 32'd0);
        check("rst.fpc",   fetch_pc, 32'h0);
        check("rst.instr", out_instr, 32'h0);
        check("rst.pc",    out_pc, 32'h0);
        check("rst.iaddr", {21'd0, imem_addr}, 32'h0);

        // Streaming: one instruction per cycle, occupancy stays at 1
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_head($sformatf("stream%0d", k), 32'(4 * k), 3'd1);
        end
        check("stream.fpc", fetch_pc, 32'h10);

        // Flush to 0 with the consumer stalled, then fill to full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        check("flush0.valid", {31'd0, out_valid}, 32'd0);
        check("flush0.fpc", fetch_pc, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check_head($sformatf("fill%0d", i), 32'h0, (i < 4) ? 3'(i) : 3'd4);
        end
        check("full.fpc",   fetch_pc, 32'h10);
        check("full.iaddr", {21'd0, imem_addr}, 32'h4);

        // Drain: first pop leaves a push bubble, then push+pop per cycle
        out_ready = 1'b1;
        step();
        check_head("drain1", 32'h4, 3'd3);
        check("drain1.fpc", fetch_pc, 32'h10);
        step();
        check_head("drain2", 32'h8, 3'd3);
        check("drain2.fpc", fetch_pc, 32'h14);
        step();
        check_head("drain3", 32'hC, 3'd3);

        // Redirect with three entries queued and the consumer ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("redir.count", {29'd0, q_count}, 32'd0);
        check("redir.valid", {31'd0, out_valid}, 32'd0);
        check("redir.fpc",   fetch_pc, 32'h100);
        check("redir.iaddr", {21'd0, imem_addr}, 32'h40);
        step();
        check_head("redir1", 32'h100, 3'd1);
        step();
        check_head("redir2", 32'h104, 3'd1);

        // Build occupancy 2, then freeze fetch and drain
        out_ready = 1'b0;
        step();
        check_head("pre_frz", 32'h104, 3'd2);
        check("pre_frz.fpc", fetch_pc, 32'h10C);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        step();
        check_head("frz1", 32'h108, 3'd1);
        check("frz1.fpc", fetch_pc, 32'h10C);
        step();
        check("frz2.valid", {31'd0, out_valid}, 32'd0);
        check("frz2.count", {29'd0, q_count}, 32'd0);
        check("frz2.instr", out_instr, 32'h0);
        check("frz2.fpc", fetch_pc, 32'h10C);
        step();
        check("frz3.fpc", fetch_pc, 32'h10C);
        fetch_en = 1'b1;
        step();
        check_head("resume", 32'h10C, 3'd1);
        check("resume.fpc", fetch_pc, 32'h110);

        // imem address wrap at 2^ADDR_W words
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1FFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.iaddr0", {21'd0, imem_addr}, 32'h7FF);
        step();
        check_head("wrap1", 32'h1FFC, 3'd1);
        check("wrap1.iaddr", {21'd0, imem_addr}, 32'h0);
        check("wrap1.fpc", fetch_pc, 32'h2000);
        step();
        check_head("wrap2", 32'h2000, 3'd1);

        // fetch_pc wrap at 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("pcwrap.fpc0", fetch_pc, 32'hFFFF_FFFC);
        step();
        check_head("pcwrap1", 32'hFFFF_FFFC, 3'd1);
        check("pcwrap1.fpc", fetch_pc, 32'h0);
        step();
        check_head("pcwrap2", 32'h0, 3'd1);

        // Asynchronous reset mid-stream with two entries queued
        out_ready = 1'b0;
        step();
        check("prerst.count", {29'd0, q_count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst.valid", {31'd0, out_valid}, 32'd0);
        check("arst.count", {29'd0, q_count}, 32'd0);
        check("arst.fpc", fetch_pc, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check_head("postrst", 32'h0, 3'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
